fu_lza_cnt: RTL and testbench
=============================

# fu_lza_cnt

Pipelined leading-zero count encoder for the FPU normalizer. Consumes the 163-bit LZA edge vector `edge_t[0:162]` produced by the LZA edge-detect stage. Produces the normalization shift amount as an 8-bit count, bit 0 being the MSB. Two registered stages, with a hold input for pipeline stalls and a flush input for kills.

## Interface
- `GRP`, default 16: bits per first-stage group. The group count is 11, with the last group covering bits 160:162.
- `NOEDGE`, default 163: count reported when no edge bit is set.
- `clk` input, 1: clock; all state updates on its rising edge.
- `rst` input, 1: reset; one clock, synchronous and active-high.
- `ex_v` input, 1: the edge vector on `ex_edge` is valid this cycle.
- `ex_edge` input, [0:162]: LZA edge vector; bit 0 is the most significant.
- `ex_hold` input, 1: stall; freezes both stages.
- `ex_flush` input, 1: kills all in-flight valids.
- `lza_v` output, 1: `lza_amt` and `lza_zero` are valid.
- `lza_amt` output, [0:7]: index of the first 1 in `ex_edge`, bit 0 is the MSB, range 0..163.
- `lza_zero` output, 1: no edge bit was set; `lza_amt` equals `NOEDGE`.

## Operation
**Stage 1 (s1)**
- Group g covers `ex_edge[16g : min(16g+15,162)]`.
- For each group, compute `any_g` (OR of its bits) and `pos_g[0:3]` (offset of the leftmost 1 within the group; 0 if none).
- Register the 11 `any` bits, 11×4 `pos` bits and `s1_v`.

**Stage 2 (s2)**
- `gsel` is the lowest g with `any_g`=1.
- `amt` = gsel×16 + `pos_gsel`. This is an 8-bit add with no overflow, since the maximum is 162.
- If no `any_g` is set: `amt`=163 (0xA3) and zero=1.
- Register `lza_amt`, `lza_zero`, `lza_v`.

**Register update rules**, for each stage in priority order:
1. `rst`=1: all valids = 0, `lza_amt` = 0, `lza_zero` = 0, s1 data = 0.
2. `ex_flush`=1: `s1_v` = 0 and `lza_v` = 0. Data registers hold. Flush wins over hold and over an incoming valid.
3. `ex_hold`=1: every register holds, including valids. `ex_v` and `ex_edge` are ignored that cycle, and the upstream stage must also hold.
4. Otherwise:
   - `s1_v` ← `ex_v`.
   - `lza_v` ← `s1_v`.
   - Stage data loads only when that stage's incoming valid is 1. When the incoming valid is 0, the data retains its old value (power gating), so `lza_amt` and `lza_zero` keep their last valid result while `lza_v`=0.
- Only the first edge bit matters. Multiple set bits are legal, and all bits after the first are don't-care.
- There is no internal data dependence between successive operands, so back-to-back valids every cycle are fully supported.

## Timing
- Latency: `ex_v` asserted in cycle N (no hold or flush) gives `lza_v`=1 in cycle N+2.
- Each hold cycle adds 1 cycle of latency to every in-flight operand.
- Throughput: 1 operand per non-held cycle.
- Reset value of every output: `lza_v`=0, `lza_amt`=0x00, `lza_zero`=0. Outputs are valid from the first cycle after `rst` deasserts.
- Reset mid-operation: all in-flight operands are discarded with no partial output. The next `lza_v` occurs at the earliest 2 cycles after the first post-reset `ex_v`.
- Flush in cycle N kills operands accepted in cycles N-1 and N-2 (those in s1 and s2). The operand presented in cycle N is also dropped. An operand presented in N+1 proceeds normally.
- Hold and flush in the same cycle: valids clear and data holds. After hold drops, no stale output appears.
- All outputs are registered, with no combinational path from any input to any output.
- Critical path: the 11-way priority select plus a 4-bit-into-8-bit add in s2. The 16-bit priority encode sits in s1.

## Test plan
1. **Reset:**
   - Stimulus: hold `rst`=1 for 2 cycles with `ex_v`=1 and `ex_edge`=all ones.
   - Required: `lza_v`=0, `lza_amt`=0, `lza_zero`=0 throughout. First valid output appears exactly 2 cycles after the first post-reset `ex_v`.
2. **Encode boundaries:**
   - Stimulus: single-bit vectors at bits 0, 15, 16, 52, 53, 159, 160, 162, applied back-to-back every cycle.
   - Required: `lza_amt` = 0, 15, 16, 52, 53, 159, 160, 162 (0xA2) on consecutive cycles starting at cycle 2, with `lza_zero`=0.
3. **Multiple bits:**
   - Stimulus: `ex_edge` with bits 37, 100 and 162 set.
   - Required: `lza_amt`=37 (0x25).
   - Stimulus: all ones.
   - Required: `lza_amt`=0.
4. **No edge:**
   - Stimulus: `ex_edge`=0 with `ex_v`=1.
   - Required: `lza_amt`=163 (0xA3), `lza_zero`=1, `lza_v`=1 two cycles later.
5. **Hold:**
   - Stimulus: stream operands A=5, B=70, C=140. Assert `ex_hold` for 3 cycles while A is in s2 and B is in s1.
   - Required: `lza_v`=1 with `lza_amt`=5 stays frozen for the 3 hold cycles. B and C then follow on the next 2 cycles, with no loss or duplication.
6. **Flush:**
   - Stimulus: in-flight operands in s1 and s2. Assert `ex_flush` together with `ex_hold` for one cycle, with `ex_v`=1.
   - Required: `lza_v`=0 for the next 2 cycles, and `lza_amt` holds its last value. An operand presented the cycle after the flush emerges normally 2 cycles later.

Source files
------------

// File: rtl/fu_lza_cnt_if.sv
// Bundle between the LZA edge-detect stage and the leading-zero count encoder.
// The edge side drives the operand, stall and kill; the encoder returns the shift amount.
interface fu_lza_cnt_if;
  logic         ex_v;
  logic [0:162] ex_edge;
  logic         ex_hold;
  logic         ex_flush;
  logic         lza_v;
  logic [0:7]   lza_amt;
  logic         lza_zero;

  modport master (
    output ex_v, ex_edge, ex_hold, ex_flush,
    input  lza_v, lza_amt, lza_zero
  );

  modport slave (
    input  ex_v, ex_edge, ex_hold, ex_flush,
    output lza_v, lza_amt, lza_zero
  );
endinterface

// File: rtl/fu_lza_cnt.sv
// Two-stage leading-zero count encoder for the FPU normalizer.
// s1: per-group OR and 16-bit priority encode; s2: group select and combine.
// Bit 0 of ex_edge is the MSB; lza_amt is the index of its first set bit.
module fu_lza_cnt #(
  parameter int unsigned GRP    = 16,
  parameter int unsigned NOEDGE = 163
) (
  input logic          clk,
  input logic          rst,
  fu_lza_cnt_if.slave  bus
);
  localparam int unsigned W    = 163;
  localparam int unsigned NGRP = (W + GRP - 1) / GRP;
  localparam int unsigned PW   = $clog2(GRP);
  localparam int unsigned GW   = $clog2(NGRP);
  localparam int unsigned PADW = NGRP * GRP;

  // Tail of the last group is padded with zeros so every group is full width.
  logic [0:PADW-1] pad;
  assign pad = {bus.ex_edge, {(PADW - W){1'b0}}};

  logic [0:NGRP-1] any_c;
  logic [PW-1:0]   pos_c [NGRP];

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    logic [0:GRP-1] bits;
    logic [PW-1:0]  pos;

    assign bits     = pad[g*GRP +: GRP];
    assign any_c[g] = |bits;
    assign pos_c[g] = pos;

    // Leftmost set bit of the group; scanning right to left so the lowest index wins.
    always_comb begin
      pos = '0;
      for (int unsigned k = 0; k < GRP; k++) begin
        if (bits[PW'(GRP - 1 - k)]) pos = PW'(GRP - 1 - k);
      end
    end
  end

  logic            s1_v;
  logic [0:NGRP-1] s1_any;
  logic [PW-1:0]   s1_pos [NGRP];

  // Stage 1 registers: valid follows ex_v, data loads only with an incoming valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_any <= '0;
      s1_pos <= '{default: '0};
    end else if (bus.ex_flush) begin
      s1_v <= 1'b0;
    end else if (!bus.ex_hold) begin
      s1_v <= bus.ex_v;
      if (bus.ex_v) begin
        s1_any <= any_c;
        s1_pos <= pos_c;
      end
    end
  end

  logic [GW-1:0] gsel;
  logic          found;
  logic [7:0]    amt_c;

  // Lowest group with an edge selects the coarse offset; its in-group position is added.
  always_comb begin
    gsel  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NGRP; k++) begin
      if (s1_any[GW'(NGRP - 1 - k)]) begin
        gsel  = GW'(NGRP - 1 - k);
        found = 1'b1;
      end
    end
    amt_c = found ? (8'(gsel) * 8'(GRP) + 8'(s1_pos[gsel])) : 8'(NOEDGE);
  end

  // Stage 2 registers: outputs keep the last valid result while lza_v is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.lza_v    <= 1'b0;
      bus.lza_amt  <= '0;
      bus.lza_zero <= 1'b0;
    end else if (bus.ex_flush) begin
      bus.lza_v <= 1'b0;
    end else if (!bus.ex_hold) begin
      bus.lza_v <= s1_v;
      if (s1_v) begin
        bus.lza_amt  <= amt_c;
        bus.lza_zero <= !found;
      end
    end
  end
endmodule

// File: tb/tb_fu_lza_cnt.sv
// Bench for fu_lza_cnt: directed edge cases followed by random traffic.
// The driver queues the expected result of each accepted operand; the monitor
// pops and compares when the operand is due at the output.
module tb_fu_lza_cnt;
  logic clk = 1'b0;
  logic rst;

  fu_lza_cnt_if bus ();

  fu_lza_cnt #(.GRP(16), .NOEDGE(163)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  amt;
    logic        zero;
    int unsigned due;
  } exp_t;

  exp_t sbq[$];

  int unsigned tick  = 0;
  int unsigned total = 0;
  int unsigned bad   = 0;

  logic cur_h = 1'b0;
  logic cur_f = 1'b0;
  logic cur_r = 1'b1;

  logic [7:0] exp_amt = '0;
  logic       exp_v   = 1'b0;
  logic       exp_z   = 1'b0;

  // Reference: index of the first set bit scanning from bit 0, or 163 if none.
  function automatic logic [7:0] ref_amt(input logic [0:162] e);
    for (int i = 0; i < 163; i++) begin
      if (e[i]) return 8'(i);
    end
    return 8'd163;
  endfunction

  function automatic logic [0:162] one_hot(input int unsigned p);
    logic [0:162] e;
    e    = '0;
    e[p] = 1'b1;
    return e;
  endfunction

  function automatic logic [0:162] rand_edge();
    logic [0:162] e;
    int unsigned  p;
    int unsigned  m;
    e = '0;
    m = $urandom_range(0, 3);
    p = $urandom_range(0, 162);
    case (m)
      1: e[p] = 1'b1;
      2: for (int unsigned i = p; i < 163; i++) e[i] = (i == p) || ($urandom_range(0, 1) == 1);
      3: for (int unsigned i = 0; i < 163; i++) e[i] = ($urandom_range(0, 7) == 0);
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic drive(input logic v, input logic [0:162] e,
                       input logic h, input logic f, input logic r);
    @(negedge clk);
    bus.ex_v     = v;
    bus.ex_edge  = e;
    bus.ex_hold  = h;
    bus.ex_flush = f;
    rst          = r;
    cur_h        = h;
    cur_f        = f;
    cur_r        = r;
    if (r || f) sbq.delete();
    else if (!h && v) sbq.push_back('{amt: ref_amt(e), zero: (e == '0), due: tick + 2});
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (tick %0d, t=%0t)", name, got, want, tick, $time);
    end
  endtask

  // Monitor: advance the expected output state one edge at a time and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (cur_r) begin
        exp_v   = 1'b0;
        exp_amt = '0;
        exp_z   = 1'b0;
      end else if (cur_f) begin
        exp_v = 1'b0;
      end else if (!cur_h) begin
        tick++;
        if (sbq.size() > 0 && sbq[0].due == tick) begin
          e       = sbq.pop_front();
          exp_v   = 1'b1;
          exp_amt = e.amt;
          exp_z   = e.zero;
        end else begin
          exp_v = 1'b0;
        end
      end
      check("lza_v",    8'(bus.lza_v),    8'(exp_v));
      check("lza_amt",  bus.lza_amt,      exp_amt);
      check("lza_zero", 8'(bus.lza_zero), 8'(exp_z));
    end
  end

  initial begin
    logic [0:162] ones;
    logic [0:162] multi;
    int unsigned  bnd [8] = '{0, 15, 16, 52, 53, 159, 160, 162};
    int unsigned  r;

    ones  = '1;
    multi = '0;
    multi[37]  = 1'b1;
    multi[100] = 1'b1;
    multi[162] = 1'b1;

    rst          = 1'b1;
    bus.ex_v     = 1'b1;
    bus.ex_edge  = ones;
    bus.ex_hold  = 1'b0;
    bus.ex_flush = 1'b0;

    // Reset held for two edges with a live all-ones operand on the input.
    drive(1'b1, ones, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Group boundaries, back to back.
    foreach (bnd[i]) drive(1'b1, one_hot(bnd[i]), 1'b0, 1'b0, 1'b0);
    idle(3);

    // Multiple set bits, all ones, no edge.
    drive(1'b1, multi, 1'b0, 1'b0, 1'b0);
    drive(1'b1, ones,  1'b0, 1'b0, 1'b0);
    drive(1'b1, '0,    1'b0, 1'b0, 1'b0);
    idle(3);

    // Hold for three cycles with A in s2 and B in s1; C offered during the hold is ignored.
    drive(1'b1, one_hot(5),  1'b0, 1'b0, 1'b0);
    drive(1'b1, one_hot(70), 1'b0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 3; i++) drive(1'b1, one_hot(140), 1'b1, 1'b0, 1'b0);
    drive(1'b1, one_hot(140), 1'b0, 1'b0, 1'b0);
    idle(3);

    // Flush together with hold and a live operand, then an operand right after.
    drive(1'b1, one_hot(9),   1'b0, 1'b0, 1'b0);
    drive(1'b1, one_hot(90),  1'b0, 1'b0, 1'b0);
    drive(1'b1, one_hot(120), 1'b1, 1'b1, 1'b0);
    drive(1'b1, one_hot(33),  1'b0, 1'b0, 1'b0);
    idle(3);

    // Random traffic including stalls, kills and occasional mid-stream reset.
    for (int unsigned n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      drive($urandom_range(0, 3) != 0, rand_edge(), (r >= 7 && r < 20) || r == 99,
            (r >= 2 && r < 7), r < 2);
    end
    idle(4);

    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
